// File: rtl/uart_ram_loader_if.sv
// Byte stream handshake from the UART reader into the RAM loader.
interface uart_ram_loader_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input  byte_ready);
   modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/uart_ram_loader.sv
// Bootloader path: parses a little-endian word count, then writes byte-pair
// words sequentially into RAM1 with a setup / WE pulse / hold sequence.
module uart_ram_loader #(
   parameter int unsigned        ADDR_W    = 18,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int unsigned        WE_CYCLES = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic               abort,
   uart_ram_loader_if.slave   bus,
   output logic [ADDR_W-1:0]  Ram1Addr,
   inout  wire  [15:0]        Ram1Data,
   output logic               Ram1OE,
   output logic               Ram1WE,
   output logic               Ram1EN,
   output logic               busy,
   output logic               done,
   output logic               overrun,
   output logic [15:0]        words_written
);

   localparam int unsigned WC_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam int unsigned WE_LAST = (WE_CYCLES > 1) ? WE_CYCLES - 1 : 0;

   typedef enum logic [3:0] {
      IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WR_SETUP, WR_PULSE, WR_HOLD, DONE
   } state_t;

   state_t            state, state_nxt;
   logic [15:0]       len, len_nxt;
   logic [15:0]       wdata, wdata_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [15:0]       count_nxt;
   logic [WC_W-1:0]   we_cnt, we_cnt_nxt;
   logic              done_nxt, overrun_nxt;
   logic              ready_q, drive_q;
   logic              accept;
   logic              ready_nxt, write_nxt, pulse_nxt, busy_nxt;

   assign bus.byte_ready = ready_q;
   assign Ram1OE         = 1'b1;
   assign Ram1Data       = drive_q ? wdata : 16'hzzzz;
   assign accept         = bus.byte_valid & ready_q;

   // State and datapath registers; strobes are registered from the next state
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= IDLE;
         len           <= '0;
         wdata         <= '0;
         Ram1Addr      <= BASE_ADDR;
         words_written <= '0;
         we_cnt        <= '0;
         done          <= 1'b0;
         overrun       <= 1'b0;
         ready_q       <= 1'b0;
         drive_q       <= 1'b0;
         Ram1EN        <= 1'b1;
         Ram1WE        <= 1'b1;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         len           <= len_nxt;
         wdata         <= wdata_nxt;
         Ram1Addr      <= addr_nxt;
         words_written <= count_nxt;
         we_cnt        <= we_cnt_nxt;
         done          <= done_nxt;
         overrun       <= overrun_nxt;
         ready_q       <= ready_nxt;
         drive_q       <= write_nxt;
         Ram1EN        <= ~write_nxt;
         Ram1WE        <= ~pulse_nxt;
         busy          <= busy_nxt;
      end
   end

   // Next-state, datapath updates and registered-output decode
   always_comb begin
      state_nxt   = state;
      len_nxt     = len;
      wdata_nxt   = wdata;
      addr_nxt    = Ram1Addr;
      count_nxt   = words_written;
      we_cnt_nxt  = we_cnt;
      done_nxt    = done;
      overrun_nxt = overrun;

      // A byte offered while we cannot take it is dropped and flagged
      if (bus.byte_valid && !ready_q && state != IDLE && state != DONE)
         overrun_nxt = 1'b1;

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = LEN_LO;
               done_nxt    = 1'b0;
               overrun_nxt = 1'b0;
               count_nxt   = '0;
               addr_nxt    = BASE_ADDR;
            end
         end
         LEN_LO: begin
            if (accept) begin
               len_nxt[7:0] = bus.byte_in;
               state_nxt    = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               len_nxt[15:8] = bus.byte_in;
               if ({bus.byte_in, len[7:0]} == 16'd0) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = DAT_LO;
               end
            end
         end
         DAT_LO: begin
            if (accept) begin
               wdata_nxt[7:0] = bus.byte_in;
               state_nxt      = DAT_HI;
            end
         end
         DAT_HI: begin
            if (accept) begin
               wdata_nxt[15:8] = bus.byte_in;
               we_cnt_nxt      = '0;
               state_nxt       = WR_SETUP;
            end
         end
         WR_SETUP: state_nxt = WR_PULSE;
         WR_PULSE: begin
            if (we_cnt == WC_W'(WE_LAST)) state_nxt = WR_HOLD;
            else                          we_cnt_nxt = we_cnt + WC_W'(1);
         end
         WR_HOLD: begin
            count_nxt = words_written + 16'd1;
            addr_nxt  = Ram1Addr + ADDR_W'(1);
            if (words_written + 16'd1 == len) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = DAT_LO;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Abort wins over everything and leaves the progress counters alone
      if (abort) begin
         state_nxt   = IDLE;
         count_nxt   = words_written;
         addr_nxt    = Ram1Addr;
         done_nxt    = done;
         overrun_nxt = overrun;
      end

      ready_nxt = (state_nxt == LEN_LO) || (state_nxt == LEN_HI) ||
                  (state_nxt == DAT_LO) || (state_nxt == DAT_HI);
      write_nxt = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                  (state_nxt == WR_HOLD);
      pulse_nxt = (state_nxt == WR_PULSE);
      busy_nxt  = (state_nxt != IDLE) && (state_nxt != DONE);
   end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader; a second instance at the top of the
// address space shadows the same byte stream to exercise address wrap.
module tb_uart_ram_loader;

   logic CLK = 1'b0;
   logic RST, start, abort;
   always #5 CLK = ~CLK;

   uart_ram_loader_if bus ();
   uart_ram_loader_if bus2 ();
   assign bus2.byte_in    = bus.byte_in;
   assign bus2.byte_valid = bus.byte_valid;

   logic [17:0] addr1, addr2;
   wire  [15:0] d1, d2;
   logic oe1, we1, en1, busy1, done1, ovr1;
   logic oe2, we2, en2, busy2, done2, ovr2;
   logic [15:0] ww1, ww2;

   uart_ram_loader #(.ADDR_W(18), .BASE_ADDR(18'h00000), .WE_CYCLES(2)) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .bus(bus),
      .Ram1Addr(addr1), .Ram1Data(d1), .Ram1OE(oe1), .Ram1WE(we1), .Ram1EN(en1),
      .busy(busy1), .done(done1), .overrun(ovr1), .words_written(ww1));

   uart_ram_loader #(.ADDR_W(18), .BASE_ADDR(18'h3FFFF), .WE_CYCLES(2)) dut2 (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort), .bus(bus2),
      .Ram1Addr(addr2), .Ram1Data(d2), .Ram1OE(oe2), .Ram1WE(we2), .Ram1EN(en2),
      .busy(busy2), .done(done2), .overrun(ovr2), .words_written(ww2));

   int total = 0;
   int bad   = 0;

   // Write log: {addr,data} captured at the first WE-low sample of each pulse
   logic [33:0] wq1[$], wq2[$];
   int wlen1[$];
   int run1 = 0, run2 = 0, en_low1 = 0, stab_err1 = 0;

   always @(negedge CLK) begin
      if (!we1) begin
         if (run1 == 0) wq1.push_back({addr1, d1});
         else if ({addr1, d1} !== wq1[$]) stab_err1++;
         run1++;
      end else if (run1 != 0) begin
         wlen1.push_back(run1);
         run1 = 0;
      end
      if (!en1) en_low1++;
      if (!we2) begin
         if (run2 == 0) wq2.push_back({addr2, d2});
         run2++;
      end else begin
         run2 = 0;
      end
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_log();
      wq1.delete(); wq2.delete(); wlen1.delete();
      en_low1 = 0; stab_err1 = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   // Waits for byte_ready before offering, so no overrun is provoked
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!bus.byte_ready && n < 200) begin @(negedge CLK); n++; end
      chk("ready_wait", 40'(n < 200), 40'(1));
      bus.byte_in = b; bus.byte_valid = 1'b1;
      @(negedge CLK);
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done1 && n < 200) begin @(negedge CLK); n++; end
      chk("done_wait", 40'(n < 200), 40'(1));
   endtask

   task automatic wait_we_low();
      int n = 0;
      while (we1 && n < 200) begin @(negedge CLK); n++; end
      chk("we_wait", 40'(n < 200), 40'(1));
   endtask

   initial begin
      RST = 1'b0; start = 1'b0; abort = 1'b0;
      bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
      @(negedge CLK); @(negedge CLK);
      chk("rst_we", 40'(we1), 40'(1));
      chk("rst_en", 40'(en1), 40'(1));
      chk("rst_oe", 40'({oe1, oe2}), 40'(2'b11));
      chk("rst_flags", 40'({busy1, done1, ovr1, bus.byte_ready}), 40'(0));
      chk("rst_ww", 40'(ww1), 40'(0));
      chk("rst_addr", 40'(addr1), 40'(0));
      chk("rst_addr2", 40'(addr2), 40'(18'h3FFFF));
      RST = 1'b1;
      @(negedge CLK);

      // Two-word load, also wrapping in the high-base instance
      clr_log();
      pulse_start();
      chk("t1_busy", 40'({busy1, bus.byte_ready, done1}), 40'(3'b110));
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h34); send_byte(8'h12);
      send_byte(8'hCD); send_byte(8'hAB);
      wait_done();
      chk("t1_done", 40'({done1, busy1, ovr1}), 40'(3'b100));
      chk("t1_ww", 40'(ww1), 40'(2));
      chk("t1_addr", 40'(addr1), 40'(2));
      chk("t1_nwr", 40'(wq1.size()), 40'(2));
      chk("t1_w0", 40'(wq1[0]), 40'({18'h00000, 16'h1234}));
      chk("t1_w1", 40'(wq1[1]), 40'({18'h00001, 16'hABCD}));
      chk("t1_welen0", 40'(wlen1[0]), 40'(2));
      chk("t1_welen1", 40'(wlen1[1]), 40'(2));
      chk("t1_enlow", 40'(en_low1), 40'(8));
      chk("t1_stable", 40'(stab_err1), 40'(0));
      chk("t1_wrap_w0", 40'(wq2[0]), 40'({18'h3FFFF, 16'h1234}));
      chk("t1_wrap_w1", 40'(wq2[1]), 40'({18'h00000, 16'hABCD}));
      chk("t1_wrap_addr", 40'(addr2), 40'(1));
      chk("t1_wrap_ww", 40'(ww2), 40'(2));

      // Zero length, with a byte offered on the start edge itself
      clr_log();
      start = 1'b1; bus.byte_in = 8'h00; bus.byte_valid = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("t2_rdy", 40'({bus.byte_ready, done1, ovr1, busy1}), 40'(4'b1001));
      @(negedge CLK);
      bus.byte_valid = 1'b0;
      chk("t2_lenhi", 40'(bus.byte_ready), 40'(1));
      send_byte(8'h00);
      wait_done();
      chk("t2_done", 40'({done1, busy1}), 40'(2'b10));
      chk("t2_ww", 40'(ww1), 40'(0));
      chk("t2_enlow", 40'(en_low1), 40'(0));
      chk("t2_nwr", 40'(wq1.size()), 40'(0));
      chk("t2_addr", 40'(addr1), 40'(0));

      // Overrun during the first WE pulse
      clr_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h34); send_byte(8'h12);
      wait_we_low();
      bus.byte_in = 8'h55; bus.byte_valid = 1'b1;
      @(negedge CLK);
      bus.byte_valid = 1'b0;
      chk("t3_ovr", 40'(ovr1), 40'(1));
      send_byte(8'h78); send_byte(8'h56);
      wait_done();
      chk("t3_w0", 40'(wq1[0]), 40'({18'h00000, 16'h1234}));
      chk("t3_w1", 40'(wq1[1]), 40'({18'h00001, 16'h5678}));
      chk("t3_ww", 40'(ww1), 40'(2));
      chk("t3_ovr_sticky", 40'(ovr1), 40'(1));

      // Abort during the second word's WE pulse, then restart
      clr_log();
      pulse_start();
      chk("t4_ovr_clr", 40'(ovr1), 40'(0));
      send_byte(8'h03); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h11);
      send_byte(8'h22); send_byte(8'h22);
      wait_we_low();
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      chk("t4_strobes", 40'({we1, en1}), 40'(2'b11));
      chk("t4_flags", 40'({busy1, bus.byte_ready, done1}), 40'(0));
      chk("t4_ww_kept", 40'(ww1), 40'(1));
      chk("t4_addr_kept", 40'(addr1), 40'(1));
      pulse_start();
      chk("t4_restart", 40'({busy1, ww1, addr1}), 40'({1'b1, 16'd0, 18'd0}));
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h44); send_byte(8'h33);
      wait_done();
      chk("t4_w", 40'(wq1[$]), 40'({18'h00000, 16'h3344}));
      chk("t4_ww", 40'(ww1), 40'(1));

      // Asynchronous reset while in DAT_HI after one committed word
      clr_log();
      pulse_start();
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h01);
      send_byte(8'hAA);
      chk("t6_pre_ww", 40'(ww1), 40'(1));
      RST = 1'b0;
      #1;
      chk("t6_strobes", 40'({we1, en1}), 40'(2'b11));
      chk("t6_flags", 40'({busy1, done1, ovr1, bus.byte_ready}), 40'(0));
      chk("t6_ww", 40'(ww1), 40'(0));
      chk("t6_addr", 40'(addr1), 40'(0));
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      clr_log();
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hEE); send_byte(8'hFF);
      wait_done();
      chk("t6_w", 40'(wq1[0]), 40'({18'h00000, 16'hFFEE}));
      chk("t6_ww_after", 40'({done1, ww1}), 40'({1'b1, 16'd1}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
